// File: rtl/bf_stdout_uart.sv
// bf_stdout_uart: consumer end of the processor's stdout/stdout_en strobe.
// Each rising edge of stdout_en queues one byte into a small FIFO. The FIFO
// drains through an 8N1 UART transmitter. cpu_en throttles the processor
// while the FIFO is full, so fast printing stalls instead of dropping bytes.
//
// Ports:
//   clk        - clock; all logic runs on its rising edge
//   reset      - synchronous, active-high reset
//   run        - upstream run request
//   stdout     - byte from the processor, valid while stdout_en is high
//   stdout_en  - processor output strobe; level, may stay high while halted
//   cpu_en     - processor enable, run & ~full (combinational)
//   tx         - UART line, idle high, registered
//   busy       - a frame is on the line or bytes are still queued
//   fifo_count - current FIFO occupancy, 0..FIFO_DEPTH
//   overflow   - sticky: a byte arrived while the FIFO was full
module bf_stdout_uart #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [7:0]         stdout,
  input  logic               stdout_en,
  output logic               cpu_en,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int              BW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]   BAUD_LAST  = BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;
  logic               r_en_d;

  // Transmitter state
  state_t             r_state;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_sh;
  logic               r_tx;

  state_t             w_state_next;
  logic [BW-1:0]      w_baud_next;
  logic [2:0]         w_bit_next;
  logic [7:0]         w_sh_next;
  logic               w_tx_next;

  logic w_accept;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_last_tick;

  // The strobe is a level that can persist across halts; only its rising
  // edge represents a new character.
  assign w_accept    = stdout_en & ~r_en_d;
  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO
  // still lands when the transmitter is taking the head.
  assign w_push      = w_accept & (~w_full | w_pop);
  assign w_last_tick = (r_baud == BAUD_LAST);

  assign cpu_en     = run & ~w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Storage has no reset so it maps onto plain RAM; the pointers define
  // which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= stdout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_en_d     <= 1'b0;
    end else begin
      r_en_d <= stdout_en;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept & ~w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_sh    <= w_sh_next;
      r_tx    <= w_tx_next;
    end
  end

  // w_tx_next is the line level for the state being entered, which keeps
  // tx a pure register output.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_last_tick ? '0 : r_baud + BW'(1);
    w_bit_next   = r_bit;
    w_sh_next    = r_sh;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_next   = 1'b1;
        w_baud_next = '0;
        if (w_pop) begin
          w_sh_next    = r_mem[r_rd_ptr];
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_last_tick) begin
          w_state_next = S_DATA;
          w_bit_next   = 3'd0;
          w_tx_next    = r_sh[0];
        end
      end
      S_DATA: begin
        if (w_last_tick) begin
          w_sh_next  = {1'b0, r_sh[7:1]};
          w_bit_next = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_tx_next = r_sh[1];
          end
        end
      end
      S_STOP: begin
        if (w_last_tick) begin
          w_state_next = S_IDLE;
          w_tx_next    = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bf_stdout_uart.sv
// Self-checking bench for bf_stdout_uart with CLK_DIV=4, FIFO_DEPTH=4.
module tb_bf_stdout_uart;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b1;
  logic [7:0]    stdout = 8'h00;
  logic          stdout_en = 1'b0;
  logic          cpu_en;
  logic          tx;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = line level during bit period i (start first)
  } vec_t;
  vec_t vecs [4];

  bf_stdout_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .run(run), .stdout(stdout), .stdout_en(stdout_en),
    .cpu_en(cpu_en), .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stdout_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Rising-edge strobe: accepted on the first edge, low again for the second.
  task automatic pulse(input logic [7:0] d);
    stdout = d;
    stdout_en = 1'b1;
    tick();
    stdout_en = 1'b0;
    tick();
  endtask

  // Wait for a start bit, then sample each bit in the middle of its period.
  task automatic rx_byte(output logic [7:0] d, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    d = 8'h00;
    while (tx !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) return;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) tick();
      d[i] = tx;
    end
    repeat (CLK_DIV) tick();
    ok = (tx === 1'b1);
  endtask

  task automatic rx_n(input int n);
    logic [7:0] d;
    bit ok;
    for (int i = 0; i < n; i++) begin
      rx_byte(d, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL rx_frame %0d: got timeout/bad stop expected frame", i);
        return;
      end
      rx_q.push_back(d);
    end
  endtask

  // Fill: one byte in flight plus DEPTH queued, accepts two edges apart.
  task automatic fill(input logic [7:0] base);
    for (int i = 0; i <= DEPTH; i++) pulse(base + 8'(i));
  endtask

  initial begin
    logic [9:0] fr;
    int extra;
    int lows;
    int stall_bad;
    bit saw_full;

    vecs[0] = '{8'h41, 10'b1010000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd1);

    // Single frames: exact timing of start/data/stop and busy release.
    for (int v = 0; v < 4; v++) begin
      stdout = vecs[v].data;
      stdout_en = 1'b1;
      tick();
      stdout_en = 1'b0;
      check($sformatf("t1_count_accept_%0h", vecs[v].data), 32'(fifo_count), 32'd1);
      repeat (3) tick();
      fr[0] = tx;
      for (int b = 1; b < 10; b++) begin
        repeat (CLK_DIV) tick();
        fr[b] = tx;
      end
      check($sformatf("t1_frame_%0h", vecs[v].data), 32'(fr), 32'(vecs[v].frame));
      tick();
      check($sformatf("t1_busy40_%0h", vecs[v].data), 32'(busy), 32'd1);
      tick();
      check($sformatf("t1_busy41_%0h", vecs[v].data), 32'(busy), 32'd0);
      check($sformatf("t1_count_end_%0h", vecs[v].data), 32'(fifo_count), 32'd0);
    end

    // Level strobe held high with the processor stalled: one byte only.
    do_reset();
    run = 1'b0;
    rx_q.delete();
    fork
      rx_n(1);
      begin
        stdout = 8'h48;
        stdout_en = 1'b1;
        tick();
        check("t2_count_one", 32'(fifo_count), 32'd1);
        check("t2_cpu_en", 32'(cpu_en), 32'd0);
        extra = 0;
        repeat (19) begin
          tick();
          if (fifo_count != 0) extra++;
        end
        stdout_en = 1'b0;
        check("t2_no_requeue", 32'(extra), 32'd0);
      end
    join
    check("t2_rx_len", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("t2_rx_byte", 32'(rx_q[0]), 32'h48);
    lows = 0;
    repeat (60) begin
      tick();
      if (tx == 1'b0) lows++;
    end
    check("t2_no_second_frame", 32'(lows), 32'd0);
    check("t2_busy_end", 32'(busy), 32'd0);
    run = 1'b1;

    // Processor model obeying cpu_en, 8 bytes into a 4-deep FIFO.
    do_reset();
    rx_q.delete();
    stall_bad = 0;
    saw_full = 1'b0;
    fork
      rx_n(8);
      begin
        int idx;
        int cnt;
        int guard;
        idx = 0;
        cnt = 4;
        guard = 0;
        while (idx < 8 && guard < 3000) begin
          if (stdout_en) begin
            stdout_en = 1'b0;
          end else if (cpu_en) begin
            cnt++;
            if (cnt >= 4) begin
              stdout = 8'h30 + 8'(idx);
              stdout_en = 1'b1;
              idx++;
              cnt = 0;
            end
          end
          tick();
          guard++;
          if (fifo_count == 3'(DEPTH)) saw_full = 1'b1;
          if (fifo_count == 3'(DEPTH) && cpu_en) stall_bad++;
        end
        stdout_en = 1'b0;
      end
    join
    check("t3_reached_full", 32'(saw_full), 32'd1);
    check("t3_cpu_en_stall", 32'(stall_bad), 32'd0);
    check("t3_overflow", 32'(overflow), 32'd0);
    check("t3_rx_len", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < rx_q.size() && i < 8; i++)
      check($sformatf("t3_rx_%0d", i), 32'(rx_q[i]), 32'(8'h30 + 8'(i)));

    // Strobe injected into a full FIFO: dropped, overflow sticky.
    do_reset();
    rx_q.delete();
    fork
      rx_n(5);
      begin
        fill(8'hC0);
        check("t4_full", 32'(fifo_count), 32'd4);
        check("t4_cpu_en_low", 32'(cpu_en), 32'd0);
        pulse(8'hEE);
        check("t4_count_kept", 32'(fifo_count), 32'd4);
        check("t4_overflow_set", 32'(overflow), 32'd1);
      end
    join
    for (int i = 0; i < rx_q.size() && i < 5; i++)
      check($sformatf("t4_rx_%0d", i), 32'(rx_q[i]), 32'(8'hC0 + 8'(i)));
    repeat (10) tick();
    check("t4_busy_end", 32'(busy), 32'd0);
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("t4_overflow_cleared", 32'(overflow), 32'd0);

    // Reset in the middle of data bit 3 with two bytes queued.
    do_reset();
    pulse(8'h11);
    pulse(8'h22);
    pulse(8'h33);
    check("t5_queued", 32'(fifo_count), 32'd2);
    repeat (12) tick();
    check("t5_bit3_low", 32'(tx), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    lows = 0;
    repeat (100) begin
      tick();
      if (tx == 1'b0) lows++;
    end
    check("t5_no_frames", 32'(lows), 32'd0);

    // Accept on the same edge the transmitter pops from a full FIFO.
    do_reset();
    rx_q.delete();
    fork
      rx_n(6);
      begin
        fill(8'hD0);
        repeat (32) tick();
        check("t6_full_before", 32'(fifo_count), 32'd4);
        stdout = 8'h5A;
        stdout_en = 1'b1;
        tick();
        stdout_en = 1'b0;
        check("t6_count_same", 32'(fifo_count), 32'd4);
        check("t6_overflow", 32'(overflow), 32'd0);
      end
    join
    check("t6_rx_len", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < rx_q.size() && i < 5; i++)
      check($sformatf("t6_rx_%0d", i), 32'(rx_q[i]), 32'(8'hD0 + 8'(i)));
    if (rx_q.size() > 5) check("t6_rx_last", 32'(rx_q[5]), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
